// File: rtl/data_memory_be.sv
// Single-port byte-enable data memory with a registered read port, valid/ready request
// handshake and a post-reset sweep that zeroes every word before the first access.
module data_memory_be #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 8,
   parameter bit CLEAR_EN = 1'b1
) (
   input  logic                  mem_clk,
   input  logic                  mem_rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  d_we,
   input  logic [DATA_W/8-1:0]   byte_en,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [DATA_W-1:0]     wdata,
   output logic [DATA_W-1:0]     rdata,
   output logic                  rvalid,
   output logic                  init_done
);

   localparam int NUM_BYTES = DATA_W / 8;
   localparam int DEPTH     = 1 << ADDR_W;

   typedef enum logic {
      ST_CLEAR,
      ST_RUN
   } state_t;

   state_t              state;
   state_t              state_next;
   logic [ADDR_W-1:0]   clr_addr;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic                clr_last;
   logic                acc;
   logic                wr_en;
   logic                rd_en;

   // Ready depends on state alone so the pipeline stall path never loops through req_valid.
   always_comb begin
      state_next = state;
      req_ready  = 1'b0;
      clr_last   = 1'b0;
      case (state)
         ST_CLEAR: begin
            clr_last = (clr_addr == '1);
            if (clr_last) begin
               state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            req_ready = 1'b1;
         end
      endcase
      acc   = req_valid & req_ready;
      wr_en = acc & d_we;
      rd_en = acc & ~d_we;
   end

   always_ff @(posedge mem_clk) begin
      if (!mem_rst_n) begin
         state     <= CLEAR_EN ? ST_CLEAR : ST_RUN;
         clr_addr  <= '0;
         init_done <= ~CLEAR_EN;
      end else begin
         state <= state_next;
         if (state == ST_CLEAR) begin
            clr_addr <= clr_addr + 1'b1;
         end
         if (clr_last) begin
            init_done <= 1'b1;
         end
      end
   end

   // The array itself is never reset; reset only blocks writes landing on the reset edge.
   always_ff @(posedge mem_clk) begin
      if (mem_rst_n) begin
         if (state == ST_CLEAR) begin
            mem[clr_addr] <= '0;
         end else if (wr_en) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
               if (byte_en[i]) begin
                  mem[addr][8*i +: 8] <= wdata[8*i +: 8];
               end
            end
         end
      end
   end

   always_ff @(posedge mem_clk) begin
      if (!mem_rst_n) begin
         rdata  <= '0;
         rvalid <= 1'b0;
      end else begin
         rvalid <= rd_en;
         if (rd_en) begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: tb/tb_data_memory_be.sv
// Bench for data_memory_be: a word-array reference model with a clear countdown is
// advanced alongside the DUT each cycle and every output is compared after each edge.
module tb_data_memory_be;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 8;
   localparam int DEPTH  = 256;

   logic                mem_clk = 1'b0;
   logic                mem_rst_n;
   logic                req_valid;
   logic                req_ready;
   logic                d_we;
   logic [1:0]          byte_en;
   logic [ADDR_W-1:0]   addr;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W-1:0]   rdata;
   logic                rvalid;
   logic                init_done;

   logic                nc_rst_n;
   logic                nc_valid;
   logic                nc_ready;
   logic                nc_we;
   logic [1:0]          nc_be;
   logic [ADDR_W-1:0]   nc_addr;
   logic [DATA_W-1:0]   nc_wdata;
   logic [DATA_W-1:0]   nc_rdata;
   logic                nc_rvalid;
   logic                nc_init;

   int                  checks   = 0;
   int                  failures = 0;

   logic [DATA_W-1:0]   model_mem [DEPTH];
   int                  clear_left = DEPTH;
   logic [DATA_W-1:0]   exp_rdata  = '0;
   logic                exp_rvalid = 1'b0;

   always #5 mem_clk = ~mem_clk;

   data_memory_be #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CLEAR_EN(1'b1)) u_dut (
      .mem_clk   (mem_clk),
      .mem_rst_n (mem_rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .d_we      (d_we),
      .byte_en   (byte_en),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata),
      .rvalid    (rvalid),
      .init_done (init_done)
   );

   data_memory_be #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CLEAR_EN(1'b0)) u_dut_noclear (
      .mem_clk   (mem_clk),
      .mem_rst_n (nc_rst_n),
      .req_valid (nc_valid),
      .req_ready (nc_ready),
      .d_we      (nc_we),
      .byte_en   (nc_be),
      .addr      (nc_addr),
      .wdata     (nc_wdata),
      .rdata     (nc_rdata),
      .rvalid    (nc_rvalid),
      .init_done (nc_init)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
      end
   endtask

   // Drives one cycle, advances the model by one edge, then compares everything after the edge.
   task automatic applyStimulus(input logic rst_n, input logic valid, input logic we,
                                input logic [1:0] be, input logic [7:0] a, input logic [15:0] wd);
      mem_rst_n = rst_n;
      req_valid = valid;
      d_we      = we;
      byte_en   = be;
      addr      = a;
      wdata     = wd;
      if (!rst_n) begin
         clear_left = DEPTH;
         exp_rdata  = '0;
         exp_rvalid = 1'b0;
      end else if (clear_left > 0) begin
         clear_left--;
         exp_rvalid = 1'b0;
         if (clear_left == 0) begin
            for (int k = 0; k < DEPTH; k++) model_mem[k] = '0;
         end
      end else if (valid && we) begin
         for (int i = 0; i < 2; i++) begin
            if (be[i]) model_mem[a][8*i +: 8] = wd[8*i +: 8];
         end
         exp_rvalid = 1'b0;
      end else if (valid) begin
         exp_rdata  = model_mem[a];
         exp_rvalid = 1'b1;
      end else begin
         exp_rvalid = 1'b0;
      end
      @(posedge mem_clk);
      #1;
      checkOutput("req_ready", req_ready, clear_left == 0);
      checkOutput("init_done", init_done, clear_left == 0);
      checkOutput("rvalid", rvalid, exp_rvalid);
      checkOutput("rdata", rdata, exp_rdata);
   endtask

   task automatic idleCycle();
      applyStimulus(1'b1, 1'b0, 1'($urandom), 2'($urandom), 8'($urandom), 16'($urandom));
   endtask

   task automatic writeWord(input logic [7:0] a, input logic [15:0] wd, input logic [1:0] be);
      applyStimulus(1'b1, 1'b1, 1'b1, be, a, wd);
   endtask

   task automatic readWord(input logic [7:0] a);
      applyStimulus(1'b1, 1'b1, 1'b0, 2'($urandom), a, 16'($urandom));
   endtask

   task automatic runClear(input string tag, input int poke_cycle);
      int n;
      n = 0;
      while (!req_ready && n < 400) begin
         if (n == poke_cycle) writeWord(8'h05, 16'hFFFF, 2'b11);
         else idleCycle();
         n++;
      end
      checkOutput(tag, n, DEPTH);
   endtask

   initial begin
      int n;
      mem_rst_n = 1'b0;
      req_valid = 1'b0;
      d_we      = 1'b0;
      byte_en   = '0;
      addr      = '0;
      wdata     = '0;
      nc_rst_n  = 1'b0;
      nc_valid  = 1'b0;
      nc_we     = 1'b0;
      nc_be     = '0;
      nc_addr   = '0;
      nc_wdata  = '0;

      // Instance without the clear engine: usable straight out of reset.
      @(posedge mem_clk);
      #1;
      checkOutput("nc_ready", nc_ready, 1);
      checkOutput("nc_init", nc_init, 1);
      checkOutput("nc_rvalid_rst", nc_rvalid, 0);
      nc_rst_n = 1'b1;
      nc_valid = 1'b1;
      nc_we    = 1'b1;
      nc_be    = 2'b11;
      nc_addr  = 8'hFF;
      nc_wdata = 16'h0001;
      @(posedge mem_clk);
      #1;
      nc_we = 1'b0;
      @(posedge mem_clk);
      #1;
      nc_valid = 1'b0;
      checkOutput("nc_rvalid", nc_rvalid, 1);
      checkOutput("nc_rdata", nc_rdata, 16'h0001);

      // Power-on clear, with a write attempted at clear cycle 100 that must be ignored.
      applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 16'h0000);
      applyStimulus(1'b0, 1'b1, 1'b1, 2'b11, 8'h05, 16'hFFFF);
      runClear("clear_len", 100);

      readWord(8'h00);
      readWord(8'h7F);
      readWord(8'hFF);
      readWord(8'h05);
      checkOutput("blocked_write", rdata, 16'h0000);

      writeWord(8'h10, 16'hA5C3, 2'b11);
      writeWord(8'h10, 16'h1234, 2'b01);
      readWord(8'h10);
      checkOutput("be_merge", rdata, 16'hA534);
      writeWord(8'h10, 16'hFFFF, 2'b00);
      readWord(8'h10);
      checkOutput("be_none", rdata, 16'hA534);

      writeWord(8'h20, 16'hBEEF, 2'b11);
      readWord(8'h20);
      checkOutput("b2b_data", rdata, 16'hBEEF);
      readWord(8'h20);
      readWord(8'h21);
      readWord(8'h22);
      idleCycle();
      writeWord(8'h23, 16'h5555, 2'b11);
      idleCycle();

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) idleCycle();
         else applyStimulus(1'b1, 1'b1, 1'($urandom), 2'($urandom), 8'($urandom_range(0, 31)), 16'($urandom));
      end

      // Reset right after a read accept clears the read port at the next edge.
      readWord(8'h10);
      applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 8'h10, 16'h0000);
      checkOutput("rst_rdata", rdata, 16'h0000);
      checkOutput("rst_rvalid", rvalid, 0);
      applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 16'h0000);
      for (int i = 0; i < 50; i++) idleCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 16'h0000);
      applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 16'h0000);
      n = -1;
      runClear("restart_len", n);
      readWord(8'h10);
      checkOutput("recleared", rdata, 16'h0000);
      readWord(8'h20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
